// File: rtl/csr_uart_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : csr_uart_rx_fifo_pkg
// Purpose  : Shared definitions for the buffered CSR UART receiver: CSR
//            modify encodings, read/write word bit positions and the receiver
//            FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package csr_uart_rx_fifo_pkg;

  // CSR modify encodings
  localparam logic [2:0] MOD_NONE  = 3'b000;
  localparam logic [2:0] MOD_WRITE = 3'b001;
  localparam logic [2:0] MOD_SET   = 3'b010;
  localparam logic [2:0] MOD_CLEAR = 3'b011;

  // Read word layout
  localparam int RD_HEAD_LSB    = 0;
  localparam int RD_EMPTY_BIT   = 8;
  localparam int RD_OVERRUN_BIT = 9;
  localparam int RD_FRAMING_BIT = 10;
  localparam int RD_COUNT_LSB   = 16;

  // Write word command bits
  localparam int WR_POP_BIT     = 0;
  localparam int WR_CLR_OVR_BIT = 1;
  localparam int WR_CLR_FRM_BIT = 2;

  // Receiver FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/csr_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : csr_sync_fifo
// Purpose  : Synchronous FIFO with wrap-bit pointers. A push into a full FIFO
//            is accepted only when a pop happens in the same cycle; a pop on
//            an empty FIFO is ignored (so push+pop on empty just pushes).
// Ports    : clk, rstn (sync, active-low)
//            push, wdata     - write side
//            pop             - read side (advances head)
//            full, empty     - status
//            count           - fill level, 0..DEPTH
//            head            - entry at the read pointer (stale when empty)
// Revision : 1.0 - initial release
// ============================================================================
module csr_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);

  localparam int c_cw = $clog2(DEPTH) + 1;
  localparam int c_aw = c_cw - 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_cw-1:0]  r_wptr;
  logic [c_cw-1:0]  r_rptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Pointers carry one extra wrap bit, so the difference is the fill level.
  assign count = r_wptr - r_rptr;
  assign full  = (count == c_cw'(DEPTH));
  assign empty = (r_wptr == r_rptr);
  assign head  = r_mem[r_rptr[c_aw-1:0]];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[c_aw-1:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/csr_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : csr_uart_rx_fifo
// Purpose  : Buffered 8N1 UART receiver exposed at a single CSR address.
//            Received bytes queue in a DEPTH-entry FIFO; software reads the
//            head, fill level and sticky error flags, and pops / clears with
//            CSR writes (the read word always shows the pre-write state).
// Ports    : clk, rstn (sync, active-low)
//            read          - CSR read strobe (unused)
//            modify[2:0]   - CSR operation
//            wdata[31:0]   - CSR write data (bit0 pop, bit1 clr ovr, bit2 clr frm)
//            addr[11:0]    - CSR address
//            rdata[31:0]   - registered read word, 0 on miss
//            valid         - registered address hit
//            rx            - asynchronous serial input, idle high
//            AVOID_WARNING - OR of otherwise unused inputs
// Revision : 1.0 - initial release
// ============================================================================
module csr_uart_rx_fifo
  import csr_uart_rx_fifo_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR  = 12'hbc2,
  parameter int          CLOCK_RATE = 12_000_000,
  parameter int          BAUD_RATE  = 115200,
  parameter int          DEPTH      = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        read,
  input  logic [2:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  input  logic        rx,
  output logic        AVOID_WARNING
);

  localparam int          c_cw       = $clog2(DEPTH) + 1;
  localparam logic [15:0] c_div_full = 16'(CLOCK_RATE / BAUD_RATE - 1);
  localparam logic [15:0] c_div_half = 16'(CLOCK_RATE / BAUD_RATE / 2 - 1);

  // --------------------------------------------------------------------------
  // rx synchroniser (resets to the idle-high line level)
  // --------------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;
  logic w_rxs;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs = r_sync2;

  // --------------------------------------------------------------------------
  // Receiver FSM
  // --------------------------------------------------------------------------
  rx_state_t   r_state;
  rx_state_t   w_state_next;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_next;
  logic [2:0]  r_bit;
  logic [2:0]  w_bit_next;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_next;
  logic        w_rx_push;
  logic        w_rx_frm_err;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_rx_push    = 1'b0;
    w_rx_frm_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_rxs) begin
          w_state_next = ST_START;
          w_cnt_next   = c_div_half;
        end
      end
      ST_START: begin
        if (r_cnt == '0) begin
          // Line must still be low at mid start bit, otherwise it was a glitch.
          if (!w_rxs) begin
            w_state_next = ST_DATA;
            w_cnt_next   = c_div_full;
            w_bit_next   = '0;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      ST_DATA: begin
        if (r_cnt == '0) begin
          w_shift_next = {w_rxs, r_shift[7:1]};
          w_cnt_next   = c_div_full;
          if (r_bit == 3'd7) w_state_next = ST_STOP;
          else               w_bit_next   = r_bit + 1'b1;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      ST_STOP: begin
        if (r_cnt == '0) begin
          w_rx_push    = w_rxs;
          w_rx_frm_err = !w_rxs;
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // CSR decode and FIFO
  // --------------------------------------------------------------------------
  logic            w_hit;
  logic            w_write;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  logic [c_cw-1:0] w_count;
  logic [7:0]      w_head;
  logic            r_overrun;
  logic            r_framing;
  logic [31:0]     w_word;

  assign w_hit   = (addr == BASE_ADDR);
  assign w_write = w_hit && (modify == MOD_WRITE);
  assign w_pop   = w_write && wdata[WR_POP_BIT];

  csr_sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (w_rx_push),
    .wdata (r_shift),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count),
    .head  (w_head)
  );

  // Sticky flags; a hardware set beats a software clear in the same cycle.
  // A full FIFO only drops the byte when no pop frees a slot this cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_overrun <= 1'b0;
      r_framing <= 1'b0;
    end else begin
      if (w_rx_push && w_full && !w_pop)            r_overrun <= 1'b1;
      else if (w_write && wdata[WR_CLR_OVR_BIT])    r_overrun <= 1'b0;
      if (w_rx_frm_err)                             r_framing <= 1'b1;
      else if (w_write && wdata[WR_CLR_FRM_BIT])    r_framing <= 1'b0;
    end
  end

  always_comb begin
    w_word                          = '0;
    w_word[RD_HEAD_LSB +: 8]        = w_empty ? 8'h00 : w_head;
    w_word[RD_EMPTY_BIT]            = w_empty;
    w_word[RD_OVERRUN_BIT]          = r_overrun;
    w_word[RD_FRAMING_BIT]          = r_framing;
    w_word[RD_COUNT_LSB +: c_cw]    = w_count;
  end

  // Captured from pre-pop / pre-clear state on the same edge as the write.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid <= 1'b0;
      rdata <= '0;
    end else begin
      valid <= w_hit;
      rdata <= w_hit ? w_word : 32'h0;
    end
  end

  assign AVOID_WARNING = read | (|wdata[31:3]);

endmodule
`default_nettype wire

// File: doc/csr_uart_rx_fifo.md
# csr_uart_rx_fifo

Buffered UART receiver on the CSR bus, sitting directly upstream of software in the RX path. It supersedes the single-character receive buffer of the character UART. It oversamples the `rx` pin, deserialises 8N1 frames into a DEPTH-entry FIFO, and exposes the FIFO head, fill level and sticky error flags at one CSR address. Software pops characters with CSR writes, so bursts up to DEPTH characters survive without polling at line rate.

## Interface
- `BASE_ADDR`, default 12'hbc2: CSR address.
- `CLOCK_RATE`, default 12_000_000: clk frequency in Hz.
- `BAUD_RATE`, default 115200: line rate. `DIV = CLOCK_RATE/BAUD_RATE`, 16 bit, DIV ≥ 4.
- `DEPTH`, default 16: FIFO entries; power of two, range 2..256. `CW = log2(DEPTH)+1`.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `read` in 1: CSR read strobe; unused.
- `modify` in 3: 000 none, 001 write, 010 set, 011 clear.
- `wdata` in 32: CSR write data.
- `addr` in 12: CSR address.
- `rdata` out 32: registered read data.
- `valid` out 1: registered address hit.
- `rx` in 1: asynchronous serial input, idle high.
- `AVOID_WARNING` out 1: OR of unused inputs (`read`, `wdata[31:3]`).

## Operation
- Read word layout:
  - [7:0] FIFO head; 0 when empty.
  - [8] empty.
  - [9] overrun, sticky.
  - [10] framing error, sticky.
  - [15:11] zero.
  - [16+CW-1:16] count.
  - Remaining bits zero.
- When `addr==BASE_ADDR` and `modify==001`, these actions occur in the same cycle the read word is captured:
  - wdata[0]=1 pops the head if non-empty; pop on empty is a no-op.
  - wdata[1]=1 clears overrun.
  - wdata[2]=1 clears framing.
- The read word always shows pre-pop, pre-clear state (CSRRW semantics).
- `modify` 010/011 and writes while `addr≠BASE_ADDR` are ignored.
- Synchroniser: two flip-flops, reset to 1. Their output is `rxs`.
- Receiver FSM:
  - **IDLE**: `rxs==0` → START, with clk counter loaded to DIV/2−1.
  - **START**: counter reaches 0 → sample `rxs`. If 0, go to DATA with counter=DIV−1 and bit=0. If 1, it is a false start → IDLE, with no flag set.
  - **DATA**: at each counter expiry, sample `rxs` into the shift register LSB-first and reload DIV−1. After bit 7 → STOP.
  - **STOP**: at counter expiry, sample `rxs`. If 1, push the byte. If 0, discard the byte and set framing. Either way → IDLE; a line still low re-triggers START on the next cycle.
- Push when full: byte dropped, overrun set, FIFO unchanged.
- Push and pop in the same cycle:
  - When full, both take effect; count stays DEPTH and overrun is not set.
  - When empty, the push lands and the pop is ignored; count becomes 1.
- Error-set and software-clear of the same flag in the same cycle: the set wins.
- Pointers are CW bits wide and wrap modulo 2·DEPTH. Full is `wptr−rptr==DEPTH`; empty is `wptr==rptr`.

## Timing
- `valid`/`rdata` are updated every cycle: `valid=(addr==BASE_ADDR)` one cycle after `addr`. `rdata` is 0 when there is no hit.
- Reset values:
  - `valid` = 0, `rdata` = 0.
  - FIFO empty (count 0), flags 0.
  - FSM IDLE; synchroniser 1.
- Reset mid-frame abandons the frame; nothing is pushed.
- A falling edge on `rx` reaches `rxs` 2 cycles later. The push lands 9·DIV + DIV/2 cycles after `rxs` falls and is visible in `rdata` one cycle after an `addr` hit sampled after the push.
- A popped entry disappears from the read word on the next read cycle. Back-to-back read+pop cycles drain one entry per cycle.

## Structure
- Shared package holds:
  - the modify encodings (MOD_WRITE=3'b001, MOD_SET=3'b010, MOD_CLEAR=3'b011);
  - the read-word bit positions;
  - the FSM state encoding (IDLE, START, DATA, STOP).
- One sub-module, `csr_sync_fifo`: parameterised width and DEPTH. It has push/pop/full/empty/count/head outputs, with the simultaneous-operation rules above. The top level holds the synchroniser, FSM and CSR decode.

## Test plan
Bench parameters: CLOCK_RATE=1_000_000, BAUD_RATE=100_000 (DIV=10), DEPTH=4.
- **Reset/idle:** hold `rstn`=0 for 3 cycles, then read BASE_ADDR → `rdata`=0x0000_0100 (empty=1), `valid`=1; read 12'hbc3 → `valid`=0, `rdata`=0.
- **Single frame:** send 0x55 at 100 kbaud, then read → `rdata`=0x0001_0055. Write wdata=1 → next read = 0x0000_0100.
- **Overrun:** send 0x01..0x05 with no pops → count=4, overrun=1, head=0x01. Pop four times → 0x01..0x04 in order. Write wdata=2 → bit 9 clears.
- **Framing/false start:** frame 0xA5 with stop bit 0 → bit 10 set, count 0. A 3-cycle low glitch on `rx` → nothing pushed, no flag.
- **Simultaneous:** FIFO full; time the pop so it coincides with the push of 0x77 → count stays 4, overrun=0, and 0x77 is the last entry read.
- **Reset mid-frame:** assert `rstn`=0 during DATA bit 4 → afterwards empty, IDLE. The next clean frame 0x3C is received correctly.
